// File: rtl/control_unit_pkg.sv
// Shared definitions for the microcoded control unit: state encodings,
// opcode constants and the bundle of bus strobes driven each cycle.
package control_unit_pkg;

  localparam int ALU_OP_W = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH_H = 3'd0;
  localparam state_t ST_FETCH_L = 3'd1;
  localparam state_t ST_EXEC    = 3'd2;
  localparam state_t ST_EXEC2   = 3'd3;
  localparam state_t ST_HALT    = 3'd4;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_LDA  = 8'h01;
  localparam logic [7:0] OPC_LDB  = 8'h02;
  localparam logic [7:0] OPC_LDM  = 8'h40;
  localparam logic [7:0] OPC_STM  = 8'h41;
  localparam logic [7:0] OPC_LDR0 = 8'h42;
  localparam logic [7:0] OPC_LDR1 = 8'h43;
  localparam logic [7:0] OPC_JMP  = 8'h50;
  localparam logic [7:0] OPC_JZ   = 8'h51;
  localparam logic [7:0] OPC_RDSR = 8'h60;

  // Opcodes 0x20-0x3F pass their low five bits straight to the ALU
  localparam logic [2:0] ALU_GROUP = 3'b001;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_opcode;
    logic we_a;
    logic we_b;
    logic we_r0;
    logic we_r1;
    logic we_ir0;
    logic we_ir1;
    logic we_pc0;
    logic we_pc1;
    logic we_m;
    logic oe_a;
    logic oe_r0;
    logic oe_r1;
    logic oe_ir0;
    logic oe_m;
    logic oe_alu;
    logic oe_sr;
    logic oe_pc;
    logic oe_r0r1;
    logic inc_pc;
  } bus_ctrl_t;

  // Both fetch cycles read memory at PC and advance it; only the IR half differs
  function automatic bus_ctrl_t fetch_ctrl(input logic high_byte);
    bus_ctrl_t c;
    c        = '0;
    c.oe_pc  = 1'b1;
    c.oe_m   = 1'b1;
    c.inc_pc = 1'b1;
    c.we_ir1 = high_byte;
    c.we_ir0 = ~high_byte;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational opcode-to-strobe table for the execute cycles, also flagging
// taken jumps (which need a second execute cycle) and the halt opcode.
module cu_decoder
  import control_unit_pkg::*;
#(
  parameter logic [7:0] HLT_OPC = 8'hFF
) (
  input  logic [7:0] opcode,
  input  logic       zero_flag,
  input  logic       second_phase,
  output bus_ctrl_t  ctrl,
  output logic       jump_taken,
  output logic       halt_op
);

  always_comb begin
    ctrl       = '0;
    jump_taken = 1'b0;
    halt_op    = 1'b0;
    if (second_phase) begin
      // Second half of a jump loads the PC high byte from R1
      ctrl.oe_r1  = 1'b1;
      ctrl.we_pc1 = 1'b1;
    end else if (opcode == HLT_OPC) begin
      halt_op = 1'b1;
    end else if (opcode[7:5] == ALU_GROUP) begin
      ctrl.alu_opcode = opcode[ALU_OP_W-1:0];
      ctrl.oe_alu     = 1'b1;
      ctrl.we_a       = 1'b1;
    end else begin
      case (opcode)
        OPC_NOP: ;
        OPC_LDA: begin ctrl.oe_ir0 = 1'b1; ctrl.we_a = 1'b1; end
        OPC_LDB: begin ctrl.oe_ir0 = 1'b1; ctrl.we_b = 1'b1; end
        OPC_LDM: begin ctrl.oe_r0r1 = 1'b1; ctrl.oe_m = 1'b1; ctrl.we_a = 1'b1; end
        OPC_STM: begin ctrl.oe_r0r1 = 1'b1; ctrl.oe_a = 1'b1; ctrl.we_m = 1'b1; end
        OPC_LDR0: begin ctrl.oe_ir0 = 1'b1; ctrl.we_r0 = 1'b1; end
        OPC_LDR1: begin ctrl.oe_ir0 = 1'b1; ctrl.we_r1 = 1'b1; end
        OPC_JMP: begin
          ctrl.oe_r0  = 1'b1;
          ctrl.we_pc0 = 1'b1;
          jump_taken  = 1'b1;
        end
        OPC_JZ: begin
          if (zero_flag) begin
            ctrl.oe_r0  = 1'b1;
            ctrl.we_pc0 = 1'b1;
            jump_taken  = 1'b1;
          end
        end
        OPC_RDSR: begin ctrl.oe_sr = 1'b1; ctrl.we_a = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer for the 8-bit datapath: two fetch cycles load the
// instruction register, then one or two execute cycles drive the bus strobes.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int         Z_BIT   = 0,
  parameter logic [7:0] HLT_OPC = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hlt,
  input  logic [15:0]         instr,
  input  logic [3:0]          status,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                WE_A,
  output logic                WE_B,
  output logic                WE_R0,
  output logic                WE_R1,
  output logic                WE_IR0,
  output logic                WE_IR1,
  output logic                WE_PC0,
  output logic                WE_PC1,
  output logic                WE_M,
  output logic                OE_A,
  output logic                OE_R0,
  output logic                OE_R1,
  output logic                OE_IR0,
  output logic                OE_M,
  output logic                OE_ALU,
  output logic                OE_SR,
  output logic                OE_PC,
  output logic                OE_R0R1,
  output logic                INC_PC,
  output logic                halted
);

  state_t    state;
  state_t    next_state;
  logic      halt_lock;
  bus_ctrl_t dec_ctrl;
  bus_ctrl_t ctrl;
  logic      jump_taken;
  logic      halt_op;
  logic      unused_inputs;

  assign unused_inputs = ^{instr[7:0], status};

  cu_decoder #(
    .HLT_OPC(HLT_OPC)
  ) u_decoder (
    .opcode      (instr[15:8]),
    .zero_flag   (status[Z_BIT]),
    .second_phase(state == ST_EXEC2),
    .ctrl        (dec_ctrl),
    .jump_taken  (jump_taken),
    .halt_op     (halt_op)
  );

  // External halt requests only take effect on the last execute cycle
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH_H: next_state = ST_FETCH_L;
      ST_FETCH_L: next_state = ST_EXEC;
      ST_EXEC: begin
        if (halt_op)         next_state = ST_HALT;
        else if (jump_taken) next_state = ST_EXEC2;
        else if (hlt)        next_state = ST_HALT;
        else                 next_state = ST_FETCH_H;
      end
      ST_EXEC2: next_state = hlt ? ST_HALT : ST_FETCH_H;
      ST_HALT: begin
        if (!halt_lock && !hlt) next_state = ST_FETCH_H;
      end
      default: next_state = ST_FETCH_H;
    endcase
  end

  // A halt opcode locks the sequencer until the next reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH_H;
      halt_lock <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_EXEC && halt_op) halt_lock <= 1'b1;
    end
  end

  // Strobes are gated by reset so an asserted reset silences the bus at once
  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state)
        ST_FETCH_H:       ctrl = fetch_ctrl(1'b1);
        ST_FETCH_L:       ctrl = fetch_ctrl(1'b0);
        ST_EXEC, ST_EXEC2: ctrl = dec_ctrl;
        default:          ctrl = '0;
      endcase
    end
  end

  assign halted     = reset && (state == ST_HALT);
  assign alu_opcode = ctrl.alu_opcode;
  assign WE_A       = ctrl.we_a;
  assign WE_B       = ctrl.we_b;
  assign WE_R0      = ctrl.we_r0;
  assign WE_R1      = ctrl.we_r1;
  assign WE_IR0     = ctrl.we_ir0;
  assign WE_IR1     = ctrl.we_ir1;
  assign WE_PC0     = ctrl.we_pc0;
  assign WE_PC1     = ctrl.we_pc1;
  assign WE_M       = ctrl.we_m;
  assign OE_A       = ctrl.oe_a;
  assign OE_R0      = ctrl.oe_r0;
  assign OE_R1      = ctrl.oe_r1;
  assign OE_IR0     = ctrl.oe_ir0;
  assign OE_M       = ctrl.oe_m;
  assign OE_ALU     = ctrl.oe_alu;
  assign OE_SR      = ctrl.oe_sr;
  assign OE_PC      = ctrl.oe_pc;
  assign OE_R0R1    = ctrl.oe_r0r1;
  assign INC_PC     = ctrl.inc_pc;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each opcode through fetch/execute and
// exercises halt, halt-lock and mid-instruction reset behaviour.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic        hlt;
  logic [15:0] instr;
  logic [3:0]  status;
  logic [4:0]  alu_opcode;
  logic WE_A, WE_B, WE_R0, WE_R1, WE_IR0, WE_IR1, WE_PC0, WE_PC1, WE_M;
  logic OE_A, OE_R0, OE_R1, OE_IR0, OE_M, OE_ALU, OE_SR, OE_PC, OE_R0R1;
  logic INC_PC, halted;
  logic [24:0] out_vec;

  int checks = 0;
  int errors = 0;

  localparam logic [24:0] M_WE_M    = 25'd1 << 5;
  localparam logic [24:0] M_WE_PC1  = 25'd1 << 6;
  localparam logic [24:0] M_WE_PC0  = 25'd1 << 7;
  localparam logic [24:0] M_WE_IR1  = 25'd1 << 8;
  localparam logic [24:0] M_WE_IR0  = 25'd1 << 9;
  localparam logic [24:0] M_WE_R1   = 25'd1 << 10;
  localparam logic [24:0] M_WE_R0   = 25'd1 << 11;
  localparam logic [24:0] M_WE_B    = 25'd1 << 12;
  localparam logic [24:0] M_WE_A    = 25'd1 << 13;
  localparam logic [24:0] M_OE_SR   = 25'd1 << 14;
  localparam logic [24:0] M_OE_ALU  = 25'd1 << 15;
  localparam logic [24:0] M_OE_M    = 25'd1 << 16;
  localparam logic [24:0] M_OE_IR0  = 25'd1 << 17;
  localparam logic [24:0] M_OE_R1   = 25'd1 << 18;
  localparam logic [24:0] M_OE_R0   = 25'd1 << 19;
  localparam logic [24:0] M_OE_A    = 25'd1 << 20;
  localparam logic [24:0] M_OE_R0R1 = 25'd1 << 21;
  localparam logic [24:0] M_OE_PC   = 25'd1 << 22;
  localparam logic [24:0] M_INC_PC  = 25'd1 << 23;
  localparam logic [24:0] M_HALTED  = 25'd1 << 24;

  localparam logic [24:0] V_NONE    = 25'd0;
  localparam logic [24:0] V_FETCH_H = M_OE_PC | M_OE_M | M_WE_IR1 | M_INC_PC;
  localparam logic [24:0] V_FETCH_L = M_OE_PC | M_OE_M | M_WE_IR0 | M_INC_PC;
  localparam logic [24:0] V_JMP1    = M_OE_R0 | M_WE_PC0;
  localparam logic [24:0] V_JMP2    = M_OE_R1 | M_WE_PC1;

  assign out_vec = {halted, INC_PC, OE_PC, OE_R0R1, OE_A, OE_R0, OE_R1, OE_IR0,
                    OE_M, OE_ALU, OE_SR, WE_A, WE_B, WE_R0, WE_R1, WE_IR0,
                    WE_IR1, WE_PC0, WE_PC1, WE_M, alu_opcode};

  control_unit dut (
    .clk(clk), .reset(reset), .hlt(hlt), .instr(instr), .status(status),
    .alu_opcode(alu_opcode),
    .WE_A(WE_A), .WE_B(WE_B), .WE_R0(WE_R0), .WE_R1(WE_R1),
    .WE_IR0(WE_IR0), .WE_IR1(WE_IR1), .WE_PC0(WE_PC0), .WE_PC1(WE_PC1),
    .WE_M(WE_M),
    .OE_A(OE_A), .OE_R0(OE_R0), .OE_R1(OE_R1), .OE_IR0(OE_IR0), .OE_M(OE_M),
    .OE_ALU(OE_ALU), .OE_SR(OE_SR), .OE_PC(OE_PC), .OE_R0R1(OE_R0R1),
    .INC_PC(INC_PC), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input logic [3:0] st,
                               input logic h);
    instr  = ins;
    status = st;
    hlt    = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expectNow(input string tag, input logic [24:0] exp_vec);
    #1;
    checkOutput(tag, {7'd0, out_vec}, {7'd0, exp_vec});
  endtask

  // Runs one instruction from its FETCH_H cycle; returns in the following cycle
  task automatic runInstr(input string tag, input logic [15:0] ins,
                          input logic [3:0] st, input logic h,
                          input logic [24:0] exec_vec, input logic two_cycle);
    applyStimulus(ins, st, 1'b0);
    expectNow({tag, "_fh"}, V_FETCH_H);
    tick();
    expectNow({tag, "_fl"}, V_FETCH_L);
    tick();
    hlt = h;
    expectNow({tag, "_ex"}, exec_vec);
    tick();
    if (two_cycle) begin
      expectNow({tag, "_ex2"}, V_JMP2);
      tick();
    end
  endtask

  // Bus-exclusivity and ALU-select rules hold in every cycle
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("data_bus_oe",
        {31'd0, ($countones({OE_A, OE_R0, OE_R1, OE_IR0, OE_M, OE_ALU, OE_SR}) <= 1)},
        32'd1);
      checkOutput("addr_bus_oe", {31'd0, ($countones({OE_PC, OE_R0R1}) <= 1)}, 32'd1);
      checkOutput("alu_idle_zero", {27'd0, (OE_ALU ? 5'd0 : alu_opcode)}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(16'h0000, 4'h0, 1'b0);
    #12;
    expectNow("reset_outputs", V_NONE);
    reset = 1'b1;

    runInstr("nop0", 16'h0000, 4'h0, 1'b0, V_NONE, 1'b0);
    runInstr("nop1", 16'h0000, 4'h0, 1'b0, V_NONE, 1'b0);
    runInstr("lda",  16'h015A, 4'h0, 1'b0, M_OE_IR0 | M_WE_A, 1'b0);
    runInstr("ldb",  16'h0233, 4'h0, 1'b0, M_OE_IR0 | M_WE_B, 1'b0);
    runInstr("alu3", 16'h2300, 4'h0, 1'b0, M_OE_ALU | M_WE_A | 25'd3, 1'b0);
    runInstr("alu1f", 16'h3F00, 4'h0, 1'b0, M_OE_ALU | M_WE_A | 25'h1F, 1'b0);
    runInstr("ldm",  16'h4000, 4'h0, 1'b0, M_OE_R0R1 | M_OE_M | M_WE_A, 1'b0);
    runInstr("stm",  16'h4100, 4'h0, 1'b0, M_OE_R0R1 | M_OE_A | M_WE_M, 1'b0);
    runInstr("ldr0", 16'h4211, 4'h0, 1'b0, M_OE_IR0 | M_WE_R0, 1'b0);
    runInstr("ldr1", 16'h4322, 4'h0, 1'b0, M_OE_IR0 | M_WE_R1, 1'b0);
    runInstr("rdsr", 16'h6000, 4'h0, 1'b0, M_OE_SR | M_WE_A, 1'b0);
    runInstr("undef", 16'h7E00, 4'h0, 1'b0, V_NONE, 1'b0);
    runInstr("jmp",  16'h5000, 4'h0, 1'b0, V_JMP1, 1'b1);
    runInstr("jz_t", 16'h5100, 4'h1, 1'b0, V_JMP1, 1'b1);
    runInstr("jz_nt", 16'h5100, 4'hE, 1'b0, V_NONE, 1'b0);

    runInstr("ldb_hlt", 16'h0200, 4'h0, 1'b1, M_OE_IR0 | M_WE_B, 1'b0);
    expectNow("hlt_enter", M_HALTED);
    tick();
    expectNow("hlt_hold", M_HALTED);
    tick();
    applyStimulus(16'h0000, 4'h0, 1'b0);
    expectNow("hlt_release", M_HALTED);
    tick();

    runInstr("jmp_hlt", 16'h5000, 4'h0, 1'b1, V_JMP1, 1'b1);
    applyStimulus(16'h0000, 4'h0, 1'b0);
    expectNow("jmp_hlt_halt", M_HALTED);
    tick();

    applyStimulus(16'h015A, 4'h0, 1'b0);
    expectNow("abort_fh", V_FETCH_H);
    tick();
    expectNow("abort_fl", V_FETCH_L);
    reset = 1'b0;
    expectNow("abort_async", V_NONE);
    tick();
    expectNow("abort_hold", V_NONE);
    reset = 1'b1;
    runInstr("post_abort", 16'h0000, 4'h0, 1'b0, V_NONE, 1'b0);

    runInstr("hlt_op", 16'hFF00, 4'h0, 1'b0, V_NONE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hlt = i[0];
      expectNow("hlt_op_lock", M_HALTED);
      tick();
    end
    reset = 1'b0;
    expectNow("hlt_op_reset", V_NONE);
    tick();
    reset = 1'b1;
    runInstr("after_lock", 16'h0000, 4'h0, 1'b0, V_NONE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
